// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer that borrows the core's shared 32-bit ALU.
// Shift-add multiply uses ALU ADD and restoring divide uses ALU SUB, one iteration per cycle.

`ifndef ALU_OP_ADD
`define ALU_OP_ADD 3'b000
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 3'b001
`endif

module alu_muldiv_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      md_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [2:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_c
);

    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [1:0]        op;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   opnd;

    logic              is_div;
    logic              running;
    logic [XLEN:0]     s;
    logic              borrow;
    logic              carry;
    logic [XLEN-1:0]   acc_nxt;
    logic [XLEN-1:0]   lo_nxt;
    logic [XLEN-1:0]   result_nxt;

    // acc/lo hold {hi,lo} for multiply and {R,Q} for divide; opnd is M or D.
    // R never needs a 33rd bit: it only keeps S when S[32]=0 (borrow case).
    assign is_div  = op[1];
    assign running = (state == RUN);
    assign s       = {acc, lo[XLEN-1]};
    assign borrow  = ~s[XLEN] & (s[XLEN-1:0] < opnd);
    assign carry   = (alu_c < acc);

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign alu_op = (running && is_div) ? `ALU_OP_SUB : `ALU_OP_ADD;
    assign alu_a  = !running ? '0 : (is_div ? s[XLEN-1:0] : acc);
    assign alu_b  = running ? opnd : '0;

    always_comb begin
        acc_nxt    = acc;
        lo_nxt     = lo;
        result_nxt = '0;
        if (is_div) begin
            if (borrow) begin
                acc_nxt = s[XLEN-1:0];
                lo_nxt  = {lo[XLEN-2:0], 1'b0};
            end else begin
                acc_nxt = alu_c;
                lo_nxt  = {lo[XLEN-2:0], 1'b1};
            end
        end else if (lo[0]) begin
            acc_nxt = {carry, alu_c[XLEN-1:1]};
            lo_nxt  = {alu_c[0], lo[XLEN-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[XLEN-1:1]};
            lo_nxt  = {acc[0], lo[XLEN-1:1]};
        end
        case (op)
            2'b00:   result_nxt = lo_nxt;
            2'b01:   result_nxt = acc_nxt;
            2'b10:   result_nxt = lo_nxt;
            default: result_nxt = acc_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op     <= 2'b00;
            cnt    <= '0;
            acc    <= '0;
            lo     <= '0;
            opnd   <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= md_op;
                        cnt   <= '0;
                        acc   <= '0;
                        lo    <= md_op[1] ? src_a : src_b;
                        opnd  <= md_op[1] ? src_b : src_a;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        result <= result_nxt;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: a stand-in ALU, a plain-arithmetic reference model,
// and a monitor that pops expected results whenever done is seen.

module tb_alu_muldiv_seq;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_c;

    int errors = 0;
    int checks = 0;
    logic [31:0] expq[$];

    alu_muldiv_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .md_op  (md_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .alu_op (alu_op),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_c  (alu_c)
    );

    always #5 clk = ~clk;

    // The core's ALU, reduced to the two operations the sequencer uses.
    assign alu_c = (alu_op == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL done_without_request: got done=1 expected done=0");
                end else begin
                    checkOutput("result", result, expq.pop_front());
                end
            end
            if (!busy) begin
                checkOutput("idle_alu_op", {29'd0, alu_op}, {29'd0, ALU_ADD});
                checkOutput("idle_alu_a", alu_a, 32'd0);
                checkOutput("idle_alu_b", alu_b, 32'd0);
            end
        end
    end

    task automatic waitDone(input string name, output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) bcnt++;
            if (done) break;
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd33);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int bcnt;
        @(negedge clk);
        md_op = op;
        src_a = a;
        src_b = b;
        start = 1'b1;
        expq.push_back(refModel(op, a, b));
        @(negedge clk);
        start = 1'b0;
        waitDone("op", lat, bcnt);
        checkOutput("busy_cycles", 32'(bcnt), 32'd33);
        @(negedge clk);
        checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
        checkOutput("done_after_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int bcnt;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        md_op = 2'b00;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_alu_op", {29'd0, alu_op}, {29'd0, ALU_ADD});
        checkOutput("reset_alu_a", alu_a, 32'd0);
        checkOutput("reset_alu_b", alu_b, 32'd0);
        rst = 1'b0;

        applyStimulus(2'b00, 32'd7, 32'd6);
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 32'd100, 32'd7);
        applyStimulus(2'b11, 32'd100, 32'd7);
        applyStimulus(2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
        applyStimulus(2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
        applyStimulus(2'b10, 32'h0000_1234, 32'd0);
        applyStimulus(2'b11, 32'h0000_1234, 32'd0);

        // start held high across a whole operation with operands changing mid-run
        @(negedge clk);
        md_op = 2'b00;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        expq.push_back(refModel(2'b00, 32'd3, 32'd5));
        @(negedge clk);
        src_a = 32'd100;
        src_b = 32'd200;
        waitDone("held", lat, bcnt);
        @(negedge clk);
        checkOutput("held_idle_busy", {31'd0, busy}, 32'd0);
        expq.push_back(refModel(2'b00, 32'd100, 32'd200));
        @(negedge clk);
        start = 1'b0;
        checkOutput("held_relaunch_busy", {31'd0, busy}, 32'd1);
        waitDone("relaunch", lat, bcnt);
        @(negedge clk);

        // reset in the middle of a divide aborts it silently
        @(negedge clk);
        md_op = 2'b10;
        src_a = 32'd1000;
        src_b = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        applyStimulus(2'b10, 32'd9, 32'd3);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(1, 255));
                2:       rb = 32'd0;
                default: rb = {1'b1, 31'($urandom)};
            endcase
            applyStimulus(rop, ra, rb);
        end

        repeat (2) @(negedge clk);
        checkOutput("queue_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
